// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing constants, also reused by regfile and issue logic.
package rob_pkg;
  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic                 valid;
    logic                 ready;
    logic [REG_IDX_W-1:0] dest;
    logic [XLEN-1:0]      data;
  } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring-buffer pointer; clr wins over inc.
module rob_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + 1'b1;
  end
endmodule

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocate at tail, complete by tag, retire one ready head entry per cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 allocValid,
  input  logic [REG_IDX_W-1:0] allocDest,
  output logic                 allocReady,
  output logic [TAG_W-1:0]     allocTag,
  input  logic                 wbValid,
  input  logic [TAG_W-1:0]     wbTag,
  input  logic [XLEN-1:0]      wbData,
  input  logic                 flush,
  output logic                 ROBwriteEnable,
  output logic [XLEN-1:0]      ROBwriteData,
  output logic [REG_IDX_W-1:0] ROBwriteIndex,
  output logic                 empty,
  output logic [TAG_W:0]       count
);
  rob_entry_t       ent [DEPTH];
  rob_entry_t       head_ent;
  logic [TAG_W-1:0] head, tail;
  logic             do_alloc, do_commit;

  assign head_ent   = ent[head];
  assign allocReady = (count != (TAG_W+1)'(DEPTH));
  assign allocTag   = tail;
  assign empty      = (count == '0);
  assign do_alloc   = allocValid && allocReady && !flush;
  assign do_commit  = head_ent.valid && head_ent.ready && !flush;

  rob_ptr #(.W(TAG_W)) u_head (.clk(clk), .rst_n(rst_n), .inc(do_commit), .clr(flush), .ptr(head));
  rob_ptr #(.W(TAG_W)) u_tail (.clk(clk), .rst_n(rst_n), .inc(do_alloc),  .clr(flush), .ptr(tail));

  // Allocation is written last so it overrides a stray writeback aimed at the free tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      if (wbValid && ent[wbTag].valid) begin
        ent[wbTag].ready <= 1'b1;
        ent[wbTag].data  <= wbData;
      end
      if (do_commit) ent[head].valid <= 1'b0;
      if (do_alloc) begin
        ent[tail].valid <= 1'b1;
        ent[tail].ready <= 1'b0;
        ent[tail].dest  <= allocDest;
        ent[tail].data  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (flush) count <= '0;
    else begin
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Retired entries with dest 0 still leave the queue but never write the regfile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ROBwriteEnable <= 1'b0;
      ROBwriteData   <= '0;
      ROBwriteIndex  <= '0;
    end else begin
      ROBwriteEnable <= do_commit && (head_ent.dest != '0);
      if (do_commit) begin
        ROBwriteData  <= head_ent.data;
        ROBwriteIndex <= head_ent.dest;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed plus random stimulus against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             allocValid;
  logic [4:0]       allocDest;
  logic             allocReady;
  logic [TAG_W-1:0] allocTag;
  logic             wbValid;
  logic [TAG_W-1:0] wbTag;
  logic [31:0]      wbData;
  logic             flush;
  logic             ROBwriteEnable;
  logic [31:0]      ROBwriteData;
  logic [4:0]       ROBwriteIndex;
  logic             empty;
  logic [TAG_W:0]   count;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .allocValid(allocValid), .allocDest(allocDest), .allocReady(allocReady), .allocTag(allocTag),
    .wbValid(wbValid), .wbTag(wbTag), .wbData(wbData), .flush(flush),
    .ROBwriteEnable(ROBwriteEnable), .ROBwriteData(ROBwriteData), .ROBwriteIndex(ROBwriteIndex),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [4:0] dest;
    logic [31:0] data;
    bit         ready;
  } m_t;

  m_t          q[$];
  int          next_tag;
  logic        exp_we;
  logic [31:0] exp_wd;
  logic [4:0]  exp_wi;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    next_tag = 0;
    exp_we = 1'b0;
    exp_wd = '0;
    exp_wi = '0;
  endtask

  task automatic check_all();
    chk("count",      32'(count),       32'(q.size()));
    chk("empty",      32'(empty),       32'(q.size() == 0));
    chk("allocReady", 32'(allocReady),  32'(q.size() != DEPTH));
    chk("allocTag",   32'(allocTag),    32'(next_tag));
    chk("wen",        32'(ROBwriteEnable), 32'(exp_we));
    chk("wdata",      ROBwriteData,     exp_wd);
    chk("windex",     32'(ROBwriteIndex), 32'(exp_wi));
  endtask

  // One clock: drive inputs, predict from pre-edge model state, advance model after the edge, check.
  task automatic step(input logic av, input logic [4:0] ad, input logic wv,
                      input logic [TAG_W-1:0] wt, input logic [31:0] wd, input logic fl);
    bit fire, com;
    allocValid = av; allocDest = ad; wbValid = wv; wbTag = wt; wbData = wd; flush = fl;
    fire = av && (q.size() != DEPTH) && !fl;
    com  = (q.size() > 0) && q[0].ready && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
      next_tag = 0;
      exp_we = 1'b0;
    end else begin
      exp_we = com && (q[0].dest != 0);
      if (com) begin
        exp_wd = q[0].data;
        exp_wi = q[0].dest;
      end
      if (wv) foreach (q[i]) if (q[i].tag == int'(wt)) begin
        q[i].ready = 1'b1;
        q[i].data  = wd;
      end
      if (com) void'(q.pop_front());
      if (fire) begin
        q.push_back('{tag: next_tag, dest: ad, data: 32'h0, ready: 1'b0});
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
    if (exp_we) pulses++;
    check_all();
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 1'b0, '0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    allocValid = 1'b0; allocDest = '0; wbValid = 1'b0; wbTag = '0; wbData = '0; flush = 1'b0;
    model_reset();
    pulses = 0;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    chk("no_pulse_idle", 32'(pulses), 32'd0);

    // Out-of-order completion, in-order retirement.
    step(1'b1, 5'd3, 1'b0, '0, 32'h0, 1'b0);
    step(1'b1, 5'd5, 1'b0, '0, 32'h0, 1'b0);
    step(1'b1, 5'd7, 1'b0, '0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd2, 32'h33, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd1, 32'h22, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h11, 1'b0);
    idle();
    chk("c0_idx", 32'(ROBwriteIndex), 32'd3); chk("c0_dat", ROBwriteData, 32'h11);
    idle();
    chk("c1_idx", 32'(ROBwriteIndex), 32'd5); chk("c1_dat", ROBwriteData, 32'h22);
    idle();
    chk("c2_idx", 32'(ROBwriteIndex), 32'd7); chk("c2_dat", ROBwriteData, 32'h33);
    repeat (2) idle();

    // Full buffer; refused alloc in the commit cycle, accepted next with wrapped tag 0.
    model_reset();
    rst_n = 1'b0; #1; rst_n = 1'b1;
    check_all();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(i + 1), 1'b0, '0, 32'h0, 1'b0);
    chk("full_ready", 32'(allocReady), 32'd0);
    step(1'b1, 5'd9, 1'b1, 3'd0, 32'hA0, 1'b0);
    step(1'b1, 5'd9, 1'b0, '0, 32'h0, 1'b0);
    chk("refused_cnt", 32'(count), 32'd7);
    chk("wrap_tag", 32'(allocTag), 32'd0);
    step(1'b1, 5'd9, 1'b0, '0, 32'h0, 1'b0);
    chk("wrap_cnt", 32'(count), 32'd8);

    // Dest-0 entry retires silently.
    step(1'b0, 5'd0, 1'b0, '0, 32'h0, 1'b1);
    step(1'b1, 5'd0, 1'b0, '0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'hDEAD, 1'b0);
    idle();
    chk("d0_wen", 32'(ROBwriteEnable), 32'd0);
    chk("d0_cnt", 32'(count), 32'd0);

    // Flush with concurrent allocate and writebacks pending.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd10 + 5'(i), 1'b0, '0, 32'h0, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd2, 32'h55, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd3, 32'h66, 1'b0);
    pulses = 0;
    step(1'b1, 5'd20, 1'b0, '0, 32'h0, 1'b1);
    chk("fl_cnt", 32'(count), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    idle(); idle();
    chk("fl_pulses", 32'(pulses), 32'd0);
    step(1'b1, 5'd21, 1'b0, '0, 32'h0, 1'b0);
    chk("fl_tag", 32'(q[0].tag), 32'd1 - 32'd1);

    // Reset right after a commit decision kills the pending pulse.
    step(1'b0, 5'd0, 1'b1, 3'd1, 32'h77, 1'b0);
    step(1'b0, 5'd0, 1'b1, 3'd0, 32'h88, 1'b0);
    idle();
    chk("pre_rst_wen", 32'(ROBwriteEnable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      logic [TAG_W-1:0] wt;
      logic [4:0]       ad;
      wt = TAG_W'($urandom_range(DEPTH - 1));
      if (q.size() > 0 && $urandom_range(3) != 0) wt = TAG_W'(q[$urandom_range(q.size() - 1)].tag);
      ad = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
      step($urandom_range(9) < 6, ad, $urandom_range(9) < 6, wt, $urandom, $urandom_range(49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
